// File: rtl/veririsc_pkg.sv
// veririsc_pkg
// Shared definitions for the VeriRISC datapath.
//   DATA_WIDTH : default datapath width in bits.
//   data_t     : one datapath word.
//   DATA_RESET : default reset constant for datapath registers.
package veririsc_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam data_t DATA_RESET = '0;

endpackage : veririsc_pkg

// File: rtl/enable_register_if.sv
// enable_register_if
// Load bus of an enable_register.
//   enable : load enable, active high (master -> slave)
//   data   : value to load           (master -> slave)
//   out    : registered value        (slave -> master)
// WIDTH must match the WIDTH of the enable_register it connects to.
interface enable_register_if
  import veririsc_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic             enable;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out;

  modport master (output enable, output data, input out);
  modport slave  (input enable, input data, output out);

endinterface : enable_register_if

// File: rtl/enable_register.sv
// enable_register
// Loadable data register with clock enable and synchronous active-high reset.
// Basic storage element of the VeriRISC datapath (accumulator, IR, ...).
//
// Ports:
//   clk  : clock, all updates on the rising edge
//   rst  : synchronous active-high reset (wins over enable)
//   bus  : enable_register_if.slave
//            enable : load enable
//            data   : value to load
//            out    : registered value, straight from the flops
//
// Parameters:
//   WIDTH       : data width in bits (>= 1), must match the bus interface
//   RESET_VALUE : value taken by out on reset
//
// Optional checking: define ENABLE_REGISTER_XCHECK_EN to compile in
// simulation-only X/Z and reset-value assertions. The register behaves the
// same with or without the macro.
module enable_register
  import veririsc_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DATA_RESET)
) (
  input logic              clk,
  input logic              rst,
  enable_register_if.slave bus
);

  // Priority: reset, then load, otherwise hold. The reset branch does not
  // look at enable or data, so X on them during reset cannot leak into out.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= RESET_VALUE;
    end else if (bus.enable) begin
      bus.out <= bus.data;
    end
  end

`ifdef ENABLE_REGISTER_XCHECK_EN
  // Simulation-only input sanity checks; never reach synthesis because the
  // macro is only defined for simulation builds.
  a_rst_known : assert property (@(posedge clk) !$isunknown(rst))
    else $error("%0t enable_register: rst is X/Z (rst=%b)", $time, rst);

  a_enable_known : assert property (@(posedge clk) !rst |-> !$isunknown(bus.enable))
    else $error("%0t enable_register: enable is X/Z while rst=0 (rst=%b enable=%b)",
                $time, rst, bus.enable);

  a_data_known : assert property (@(posedge clk) (!rst && bus.enable) |-> !$isunknown(bus.data))
    else $error("%0t enable_register: data is X/Z on a load (enable=%b data=%h)",
                $time, bus.enable, bus.data);

  a_reset_value : assert property (@(posedge clk) rst |=> (bus.out == RESET_VALUE))
    else $error("%0t enable_register: out=%h after reset, expected %h",
                $time, bus.out, RESET_VALUE);
`endif

endmodule : enable_register

// File: tb/tb_enable_register.sv
// tb_enable_register
// Directed bench for enable_register: one default 8-bit instance and one
// 16-bit instance with RESET_VALUE = 16'hBEEF, driven with the same control.
// A behavioural model tracks the expected register contents and is compared
// every cycle; literal checks pin the model against hand-computed values.
module tb_enable_register;
  import veririsc_pkg::*;

  localparam logic [15:0] RV16 = 16'hBEEF;

  logic clk;
  logic rst;

  enable_register_if #(.WIDTH(8))  bus8  ();
  enable_register_if #(.WIDTH(16)) bus16 ();

  enable_register dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  enable_register #(
    .WIDTH       (16),
    .RESET_VALUE (RV16)
  ) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: what each register must hold after the latest edge.
  data_t       exp8;
  logic [15:0] exp16;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      exp8        = DATA_RESET;
      exp16       = RV16;
      model_valid = 1'b1;
    end else if (bus8.enable === 1'b1) begin
      exp8  = bus8.data;
      exp16 = bus16.data;
    end
  end

  // Per-cycle compare, on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp++;
      if (bus8.out !== exp8) begin
        n_bad++;
        $display("FAIL model8 t=%0t out=%h expected=%h", $time, bus8.out, exp8);
      end
      n_cmp++;
      if (bus16.out !== exp16) begin
        n_bad++;
        $display("FAIL model16 t=%0t out=%h expected=%h", $time, bus16.out, exp16);
      end
    end
  end

  // Literal check, one line per transaction.
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t out=%h expected=%h", name, $time, act, exp);
    end else begin
      $display("pass %s t=%0t out=%h", name, $time, act);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [7:0] d8, input logic [15:0] d16);
    rst          = r;
    bus8.enable  = en;
    bus16.enable = en;
    bus8.data    = d8;
    bus16.data   = d16;
  endtask

  // Let one rising edge take the current inputs, then settle 2 ns past it.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with X on enable and data.
    drive(1'b1, 1'bx, 8'hxx, 16'hxxxx);
    cyc();
    check("reset_x_8",  {8'h00, bus8.out}, 16'h0000);
    check("reset_x_16", bus16.out, 16'hBEEF);

    // Hold after reset with X data.
    drive(1'b0, 1'b0, 8'hxx, 16'hxxxx);
    cyc();
    check("hold_rst_a", {8'h00, bus8.out}, 16'h0000);
    cyc();
    check("hold_rst_b", {8'h00, bus8.out}, 16'h0000);
    check("hold_rst_16", bus16.out, 16'hBEEF);

    // Load, then hold while data changes.
    drive(1'b0, 1'b1, 8'hAA, 16'h1234);
    cyc();
    check("load_aa",   {8'h00, bus8.out}, 16'h00AA);
    check("load_1234", bus16.out, 16'h1234);
    drive(1'b0, 1'b0, 8'h55, 16'hFFFF);
    cyc();
    check("hold_aa_a", {8'h00, bus8.out}, 16'h00AA);
    cyc();
    check("hold_aa_b", {8'h00, bus8.out}, 16'h00AA);
    check("hold_1234", bus16.out, 16'h1234);

    // Reset asserted mid-cycle alongside a load: nothing until the edge,
    // then reset wins over enable.
    drive(1'b1, 1'b1, 8'hFF, 16'hFFFF);
    #3;
    check("mid_rst_no_effect", {8'h00, bus8.out}, 16'h00AA);
    cyc();
    check("rst_prio_8",  {8'h00, bus8.out}, 16'h0000);
    check("rst_prio_16", bus16.out, 16'hBEEF);

    // Reload after reset, then hold.
    drive(1'b0, 1'b1, 8'h55, 16'h5555);
    cyc();
    check("reload_55", {8'h00, bus8.out}, 16'h0055);
    drive(1'b0, 1'b0, 8'hAA, 16'hAAAA);
    cyc();
    check("final_55",   {8'h00, bus8.out}, 16'h0055);
    check("final_5555", bus16.out, 16'h5555);

    // Back-to-back loads on consecutive edges.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 8'(i), 16'(i * 16'h0101));
      cyc();
      check($sformatf("b2b_%0d_8", i),  {8'h00, bus8.out}, 16'(i));
      check($sformatf("b2b_%0d_16", i), bus16.out, 16'(i * 16'h0101));
    end

    // Mixed load/hold pattern, checked by the model each cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'(i % 3 != 1), 8'($urandom), 16'($urandom));
      cyc();
    end

    // Reset with enable low, then all-ones load at the top boundary.
    drive(1'b1, 1'b0, 8'h77, 16'h7777);
    cyc();
    check("rst_en0_8",  {8'h00, bus8.out}, 16'h0000);
    check("rst_en0_16", bus16.out, 16'hBEEF);
    drive(1'b0, 1'b1, 8'hFF, 16'hFFFF);
    cyc();
    check("load_ff",   {8'h00, bus8.out}, 16'h00FF);
    check("load_ffff", bus16.out, 16'hFFFF);
    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    cyc();
    check("hold_ff", {8'h00, bus8.out}, 16'h00FF);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_enable_register

// File: doc/enable_register.md
# enable_register

8-bit (parameterisable) loadable data register with clock enable and synchronous active-high reset. It is the basic storage element of the VeriRISC datapath, used for the accumulator, instruction register and similar state. Each rising clock edge it either clears, loads `data`, or holds its current value.

## Interface
Parameters:
- `WIDTH`, default 8: data and output width in bits, minimum 1.
- `RESET_VALUE`, default `'0`: value loaded into `out` by reset, `WIDTH` bits.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset. Sampled only on the rising edge of `clk`.
- `enable`  input  1: load enable, active high.
- `data`  input  WIDTH: value to load.
- `out`  output  WIDTH: registered value, driven directly from the storage flops.

## Operation
- Priority on each rising `clk` edge: `rst` first, then `enable`, then hold.
  - `rst`=1: `out` <= `RESET_VALUE`, whatever `enable` and `data` are, including X or Z values.
  - `rst`=0, `enable`=1: `out` <= `data`.
  - `rst`=0, `enable`=0: `out` holds its value, and `data` changes are ignored.
- No combinational path from any input to `out`.
- Reset mid-operation: reset wins on the edge it is sampled, even when `enable`=1 on the same edge. The next edge with `rst`=0 resumes normal load/hold.
- Before the first reset edge, `out` is unknown (X in simulation). There is no power-on initialiser.
- `enable` = X with `rst`=0 is an illegal input condition. Behaviour is covered under Configuration.

## Timing
- Load latency is 1 cycle: `data` sampled at edge N appears on `out` just after edge N.
- Reset latency is 1 cycle: `out` = `RESET_VALUE` just after the first edge with `rst`=1. Asserting `rst` between edges has no effect until the next edge.
- Reset value of `out` is `RESET_VALUE`, which is 0x00 by default.
- Back-to-back loads on consecutive edges are supported. Every edge with `enable`=1 captures new data.
- Hold is indefinite while `enable`=0 and `rst`=0.

## Configuration
- `ENABLE_REGISTER_XCHECK_EN`, when defined, compiles in simulation-only concurrent assertions at each rising `clk` edge:
  - `rst` must not be X or Z.
  - When `rst`=0, `enable` must not be X or Z.
  - When `rst`=0 and `enable`=1, `data` must not be X or Z.
  - After any edge where `rst` was 1, `out` must equal `RESET_VALUE`.
  - Each failure reports an `$error` with time and signal values.
- When the macro is not defined, no checking logic is present. RTL behaviour is identical either way, and all checks are excluded from synthesis.

## Structure
- Shared package `veririsc_pkg` holds:
  - `DATA_WIDTH` = 8, used as the default for `WIDTH`.
  - typedef `data_t` = `logic [DATA_WIDTH-1:0]`.
  - the default reset constant `DATA_RESET` = '0.
- Single module. No sub-module is needed: one `always_ff` block with an if/else-if priority chain, plus the optional assertion block.

## Test plan
Clock period is 20 ns.
- Reset with X on other inputs: `rst`=1, `enable`=X, `data`=X for one edge -> `out`=0x00 after that edge.
- Hold after reset: `rst`=0, `enable`=0, `data`=X -> `out` stays 0x00 across 2 edges.
- Load: `enable`=1, `data`=0xAA -> `out`=0xAA after 1 edge. Then `enable`=0, `data`=0x55 -> `out` stays 0xAA.
- Reset priority: `rst`=1 with `enable`=1, `data`=0xFF -> `out`=0x00. Asserting `rst` mid-cycle leaves `out` unchanged until the next edge.
- Reload after reset: `rst`=0, `enable`=1, `data`=0x55 -> `out`=0x55. Then `enable`=0, `data`=0xAA -> `out` stays 0x55. Final check `out`==0x55 prints pass.
- Back-to-back loads 0x01, 0x02, 0x03 on consecutive edges -> `out` follows with 1-cycle latency. Repeat at `WIDTH`=16 with `RESET_VALUE`=0xBEEF: reset gives `out`=0xBEEF.
